accum_sequencer: RTL
====================

# accum_sequencer

Control unit for the lab 3 switch/accumulator datapath. It synchronizes and debounces the raw active-low Run_Accumulate button and turns each press into exactly one register commit. It drives the register load enable and the mux select (load switches or load sum), and waits a programmable settle time before each commit so a slow ripple adder can finish. It also keeps a saturating accumulation count and a sticky carry-out flag for the display logic.

## Interface
- DEBOUNCE_CYCLES, default 16'd50000: consecutive stable synchronized samples required before the debounced level changes; legal range 1..65535.
- SETTLE_CYCLES, default 4: cycles waited between press detection and commit; legal range 1..255.
- Clk  in  1  system clock; all state on rising edge.
- Reset_Clear  in  1  asynchronous, active-low reset.
- Run_Accumulate  in  1  raw button: low = pressed; asynchronous to Clk; may bounce.
- Cout  in  1  adder carry-out (S[16]); sampled only in COMMIT.
- Reg_Ld  out  1  one-cycle load enable for the 17-bit accumulator register.
- Sel_Sum  out  1  mux select: 0 = load SW[15:0], 1 = load adder sum.
- Busy  out  1  high in SETTLE, COMMIT and RELEASE.
- Acc_Count  out  8  number of sum commits since reset; saturates at 8'hFF.
- Carry_Flag  out  1  sticky: set when Cout = 1 during a sum commit.

## Operation
- Reset (Reset_Clear low): state IDLE. Reg_Ld = 0, Sel_Sum = 0, Busy = 0, Acc_Count = 0, Carry_Flag = 0. The internal loaded flag is 0. Both sync flops, the debounced level and the previous-level flop reset to 1 (released). The debounce counter resets to 0.
- Debounce: a 2-flop synchronizer feeds sync2.
  - If sync2 equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes sync2 and the counter clears.
- Press: the debounced level is 0 and the previous level is 1, registered as a one-cycle press pulse.
- FSM:
  - IDLE: on press, go to SETTLE and load the settle counter with SETTLE_CYCLES−1.
  - SETTLE: decrement the counter. When it is 0, go to COMMIT.
  - COMMIT (exactly one cycle): Reg_Ld = 1 and Sel_Sum = loaded.
    - If loaded = 0, set loaded to 1 (this commit is the switch load).
    - If loaded = 1, increment Acc_Count (saturating) and OR Cout into Carry_Flag.
    - Go to RELEASE.
  - RELEASE: wait until the debounced level is 1, then go to IDLE.
- Sel_Sum is registered, equals loaded at all times, and is stable during SETTLE so the mux output settles before the commit.
- A press while Busy cannot occur (RELEASE needs a release first); no press is queued.
- Reset mid-operation: returns immediately to IDLE with the reset values above; no partial commit.
- A button still held when reset releases is seen as a new press after debounce, which produces a switch load.

## Timing
- Edge 0 is the first Clk edge that samples Run_Accumulate low, with the input held low from then on.
  - Debounced level goes to 0 at edge DEBOUNCE_CYCLES+1.
  - Press pulse registers at edge DEBOUNCE_CYCLES+2.
  - SETTLE is entered at edge DEBOUNCE_CYCLES+3.
  - Reg_Ld is high for exactly the one cycle after edge DEBOUNCE_CYCLES+SETTLE_CYCLES+3.
- Bounce: any low pulse shorter than DEBOUNCE_CYCLES synchronized samples produces no press. The same applies to releases.
- Reg_Ld is never high for two consecutive cycles. There is exactly one Reg_Ld pulse per debounced press.
- Acc_Count and Carry_Flag update on the edge that ends COMMIT.

## Structure
- Package accum_seq_pkg holds:
  - state_t enum {IDLE, SETTLE, COMMIT, RELEASE};
  - CNT_W = 8 and the Acc_Count saturation value 8'hFF.
- Sub-module btn_debounce (Clk, Reset_Clear, raw_n, level_n, press_pulse) contains the synchronizer, debounce counter and edge detect. The FSM, counters and flags stay in accum_sequencer.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SETTLE_CYCLES=2.
- Clean press from reset, held low from edge 0 → Reg_Ld high only in the cycle after edge 9; Sel_Sum=0; Acc_Count=0; Busy high edges 7–10 until release debounces.
- Release, then a second press with Cout=1 at commit → Sel_Sum=1 during the Reg_Ld cycle; Acc_Count=1; Carry_Flag=1.
- Bounce: raw low for 3 cycles, high 2, low 2, high → no Reg_Ld, state stays IDLE, Busy=0.
- 257 accumulate presses after the initial load with Cout=0 → Acc_Count saturates at 8'hFF; Carry_Flag stays 0.
- Reset_Clear pulsed low during SETTLE → all outputs 0 immediately; no Reg_Ld pulse; next press gives Sel_Sum=0.
- Button held continuously for 100 cycles → exactly one Reg_Ld pulse; Busy stays high until release plus 6 cycles.

Source files
------------

// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the switch/accumulator control unit.
package accum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMMIT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] ACC_SAT = 8'hFF;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces an active-low push button; emits a one-cycle
// pulse on each debounced press (falling edge of the debounced level).
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic Clk,
    input  logic Reset_Clear,
    input  logic raw_n,
    output logic level_n,
    output logic press_pulse
);

    logic        sync1;
    logic        sync2;
    logic        prev_n;
    logic [15:0] db_cnt;

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            level_n     <= 1'b1;
            prev_n      <= 1'b1;
            db_cnt      <= 16'd0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= raw_n;
            sync2       <= sync1;
            prev_n      <= level_n;
            press_pulse <= prev_n & ~level_n;
            // Any sample agreeing with the current level restarts the stability count.
            if (sync2 == level_n) begin
                db_cnt <= 16'd0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                level_n <= sync2;
                db_cnt  <= 16'd0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/accum_sequencer.sv
// Turns each debounced Run_Accumulate press into one accumulator commit,
// after a settle delay; tracks a saturating sum-commit count and sticky carry.
module accum_sequencer
    import accum_seq_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  SETTLE_CYCLES   = 8'd4
) (
    input  logic             Clk,
    input  logic             Reset_Clear,
    input  logic             Run_Accumulate,
    input  logic             Cout,
    output logic             Reg_Ld,
    output logic             Sel_Sum,
    output logic             Busy,
    output logic [CNT_W-1:0] Acc_Count,
    output logic             Carry_Flag,
    output state_t           dbg_state
);

    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic             loaded_q, loaded_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             level_n;
    logic             press_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .Clk        (Clk),
        .Reset_Clear(Reset_Clear),
        .raw_n      (Run_Accumulate),
        .level_n    (level_n),
        .press_pulse(press_pulse)
    );

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            state_q  <= IDLE;
            settle_q <= 8'd0;
            loaded_q <= 1'b0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            loaded_q <= loaded_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        loaded_d = loaded_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (press_pulse) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_CYCLES - 8'd1;
                end
            end
            SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = COMMIT;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            COMMIT: begin
                // First commit after reset loads the switches; later ones load the sum.
                if (!loaded_q) begin
                    loaded_d = 1'b1;
                end else begin
                    if (acc_q != ACC_SAT) begin
                        acc_d = acc_q + CNT_W'(1);
                    end
                    carry_d = carry_q | Cout;
                end
                state_d = RELEASE;
            end
            RELEASE: begin
                if (level_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reg_Ld is a one-cycle strobe with no back-pressure: the register loads
    // on the rising edge that ends the COMMIT cycle.
    assign Reg_Ld     = (state_q == COMMIT);
    assign Sel_Sum    = loaded_q;
    assign Busy       = (state_q != IDLE);
    assign Acc_Count  = acc_q;
    assign Carry_Flag = carry_q;
    assign dbg_state  = state_q;

endmodule
